// File: rtl/arm_cond_pkg.sv
// Shared ARM condition-code constants and flag/FlagW bit positions.
// Used by condlogic and condcheck.
package arm_cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  localparam int N = 3;
  localparam int Z = 2;
  localparam int C = 1;
  localparam int V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/condlogic_condcheck.sv
// condcheck: evaluates an ARM condition field against {N,Z,C,V}.
// Pure combinational; NV evaluates as pass here and is masked by the caller.
module condcheck
  import arm_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v, ge;

  always_comb begin
    n  = flags[N];
    z  = flags[Z];
    c  = flags[C];
    v  = flags[V];
    ge = (n == v);
    cond_ex = 1'b1;
    case (cond)
      EQ: cond_ex = z;
      NE: cond_ex = ~z;
      CS: cond_ex = c;
      CC: cond_ex = ~c;
      MI: cond_ex = n;
      PL: cond_ex = ~n;
      VS: cond_ex = v;
      VC: cond_ex = ~v;
      HI: cond_ex = c & ~z;
      LS: cond_ex = ~(c & ~z);
      GE: cond_ex = ge;
      LT: cond_ex = ~ge;
      GT: cond_ex = ~z & ge;
      LE: cond_ex = ~(~z & ge);
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/condlogic.sv
// condlogic: NZCV flag register, condition evaluation and write-enable gating.
// Optional sticky NV trap enabled by defining CONDLOGIC_NV_TRAP_EN.
module condlogic
  import arm_cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       Stall,
  output logic       CondEx,
  output logic [3:0] Flags,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondFault
);

  logic       cond_raw;
  logic [1:0] flags_nz_q, flags_nz_d;
  logic [1:0] flags_cv_q, flags_cv_d;
  logic       cond_ex_dly_q, cond_ex_dly_d;

  condcheck u_condcheck (
    .cond    (Cond),
    .flags   (Flags),
    .cond_ex (cond_raw)
  );

  assign CondEx = cond_raw & (Cond != NV);
  assign Flags  = {flags_nz_q, flags_cv_q};

  always_comb begin
    flags_nz_d    = flags_nz_q;
    flags_cv_d    = flags_cv_q;
    cond_ex_dly_d = cond_ex_dly_q;
    if (!Stall) begin
      cond_ex_dly_d = CondEx;
      if (FlagW[FW_NZ] && CondEx) flags_nz_d = ALUFlags[N:Z];
      if (FlagW[FW_CV] && CondEx) flags_cv_d = ALUFlags[C:V];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_nz_q <= 2'b00;
    else        flags_nz_q <= flags_nz_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_cv_q <= 2'b00;
    else        flags_cv_q <= flags_cv_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cond_ex_dly_q <= 1'b0;
    else        cond_ex_dly_q <= cond_ex_dly_d;
  end

`ifdef CONDLOGIC_NV_TRAP_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d = fault_q;
    if (!Stall && (Cond == NV)) fault_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  assign CondFault = fault_q;
`else
  assign CondFault = 1'b0;
`endif

  // reset also gates NextPC, so nothing writes while the core is held in reset
  assign PCWrite  = reset & ~Stall & ((PCS & cond_ex_dly_q) | NextPC);
  assign RegWrite = reset & ~Stall & RegW & cond_ex_dly_q;
  assign MemWrite = reset & ~Stall & MemW & cond_ex_dly_q;

endmodule

// File: tb/tb_condlogic.sv
// Scoreboard bench for condlogic: directed scenarios plus random traffic
// against a behavioural model of the flag register and write gating.
module tb_condlogic;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW, Stall;
  logic       CondEx, PCWrite, RegWrite, MemWrite, CondFault;
  logic [3:0] Flags;

  always #5 clk = ~clk;

  condlogic dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Stall(Stall),
    .CondEx(CondEx), .Flags(Flags), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .CondFault(CondFault)
  );

  typedef struct {
    logic       cex;
    logic [3:0] flags;
    logic       pcw, rw, mw, flt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] m_flags = 4'b0000;
  logic       m_cexd  = 1'b0;
  logic       m_flt   = 1'b0;

  function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check1(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.cex   = ref_pass(Cond, m_flags);
    e.flags = m_flags;
    e.pcw   = reset && !Stall && ((PCS && m_cexd) || NextPC);
    e.rw    = reset && !Stall && RegW && m_cexd;
    e.mw    = reset && !Stall && MemW && m_cexd;
    e.flt   = m_flt;
    return e;
  endfunction

  // Clock-edge effect of the inputs that were stable across the edge.
  task automatic model_edge();
    logic pass;
    if (reset && !Stall) begin
      pass = ref_pass(Cond, m_flags);
      if (FlagW[1] && pass) m_flags[3:2] = ALUFlags[3:2];
      if (FlagW[0] && pass) m_flags[1:0] = ALUFlags[1:0];
      m_cexd = pass;
`ifdef CONDLOGIC_NV_TRAP_EN
      if (Cond == 4'hF) m_flt = 1'b1;
`endif
    end
  endtask

  task automatic cyc(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                     input logic pcs, input logic npc, input logic rw, input logic mw,
                     input logic st, input logic rst);
    @(posedge clk);
    model_edge();
    #1;
    Cond = c; ALUFlags = alu; FlagW = fw; PCS = pcs; NextPC = npc;
    RegW = rw; MemW = mw; Stall = st; reset = rst;
    if (!rst) begin
      m_flags = 4'b0000; m_cexd = 1'b0; m_flt = 1'b0;
    end
    sbq.push_back(model_out());
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check1("CondEx",    {3'b0, CondEx},    {3'b0, e.cex});
      check1("Flags",     Flags,             e.flags);
      check1("PCWrite",   {3'b0, PCWrite},   {3'b0, e.pcw});
      check1("RegWrite",  {3'b0, RegWrite},  {3'b0, e.rw});
      check1("MemWrite",  {3'b0, MemWrite},  {3'b0, e.mw});
      check1("CondFault", {3'b0, CondFault}, {3'b0, e.flt});
    end
  end

  initial begin
    logic exp_flt;
`ifdef CONDLOGIC_NV_TRAP_EN
    exp_flt = 1'b1;
`else
    exp_flt = 1'b0;
`endif
    reset = 1'b0; Cond = 4'hE; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0; Stall = 1'b0;

    // reset with everything requested
    cyc(4'hE, 4'hF, 2'b11, 1, 1, 1, 1, 0, 0);
    cyc(4'h3, 4'hA, 2'b11, 1, 1, 1, 1, 0, 0);
    #1;
    check1("rst_Flags",    Flags,              4'h0);
    check1("rst_PCWrite",  {3'b0, PCWrite},    4'h0);
    check1("rst_RegWrite", {3'b0, RegWrite},   4'h0);
    check1("rst_MemWrite", {3'b0, MemWrite},   4'h0);
    check1("rst_Fault",    {3'b0, CondFault},  4'h0);
    cyc(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1);
    cyc(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1);
    #1;
    check1("rel_CondEx", {3'b0, CondEx}, 4'h1);

    // full flag write then EQ sees the new Z
    cyc(4'hE, 4'h6, 2'b11, 0, 0, 0, 0, 0, 1);
    cyc(4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1);
    #1;
    check1("full_Flags", Flags, 4'h6);
    check1("full_EQ",    {3'b0, CondEx}, 4'h1);

    // partial writes
    cyc(4'hE, 4'h9, 2'b10, 0, 0, 0, 0, 0, 1);
    cyc(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1);
    #1;
    check1("part_NZ", Flags, 4'hA);
    cyc(4'hE, 4'h6, 2'b11, 0, 0, 0, 0, 0, 1);
    cyc(4'hE, 4'h9, 2'b01, 0, 0, 0, 0, 0, 1);
    cyc(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1);
    #1;
    check1("part_CV", Flags, 4'h5);

    // gating with a failed EQ, then NextPC bypass
    cyc(4'hE, 4'h0, 2'b11, 0, 0, 0, 0, 0, 1);
    cyc(4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1);
    cyc(4'h0, 4'h0, 2'b00, 1, 0, 1, 1, 0, 1);
    #1;
    check1("gate_fail", {1'b0, PCWrite, RegWrite, MemWrite}, 4'h0);
    cyc(4'h0, 4'h0, 2'b00, 1, 1, 1, 1, 0, 1);
    #1;
    check1("gate_nextpc", {1'b0, PCWrite, RegWrite, MemWrite}, 4'h4);

    // gating with a passing EQ
    cyc(4'hE, 4'h4, 2'b11, 0, 0, 0, 0, 0, 1);
    cyc(4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1);
    cyc(4'h0, 4'h0, 2'b00, 1, 0, 1, 1, 0, 1);
    #1;
    check1("gate_pass", {1'b0, PCWrite, RegWrite, MemWrite}, 4'h7);

    // stall freezes flags and suppresses writes
    for (int i = 0; i < 3; i++) begin
      cyc(4'h0, 4'hF, 2'b11, 0, 1, 1, 0, 1, 1);
      #1;
      check1("stall_RegWrite", {3'b0, RegWrite}, 4'h0);
      check1("stall_PCWrite",  {3'b0, PCWrite},  4'h0);
      check1("stall_Flags",    Flags,            4'h4);
    end
    cyc(4'h0, 4'h0, 2'b00, 0, 0, 1, 0, 0, 1);
    #1;
    check1("unstall_RegWrite", {3'b0, RegWrite}, 4'h1);

    // NV handling
    cyc(4'hF, 4'h0, 2'b11, 0, 0, 0, 0, 0, 1);
    #1;
    check1("nv_CondEx", {3'b0, CondEx}, 4'h0);
    cyc(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1);
    #1;
    check1("nv_Fault", {3'b0, CondFault}, {3'b0, exp_flt});
    cyc(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1);
    #1;
    check1("nv_Fault_sticky", {3'b0, CondFault}, {3'b0, exp_flt});
    cyc(4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    #1;
    check1("nv_Fault_rst", {3'b0, CondFault}, 4'h0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(4'($urandom_range(15)), 4'($urandom_range(15)), 2'($urandom_range(3)),
          1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
          1'($urandom_range(1)), ($urandom_range(3) == 0), ($urandom_range(40) != 0));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/condlogic.md
# condlogic

Conditional-execution logic for the multicycle ARM datapath. It sits between the controller's decoder and the condition evaluator (`condcheck`). It holds the architectural NZCV flag register, feeds those flags to `condcheck`, and registers the resulting condition. It then gates the controller's PC, register-file and memory write requests so that only instructions whose condition passes can change architectural state.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- Cond  input  4  condition field, Instr[31:28]
- ALUFlags  input  4  {N,Z,C,V} from the ALU this cycle
- FlagW  input  2  flag-write request: [1] writes N,Z; [0] writes C,V
- PCS  input  1  instruction writes PC (branch or write to R15)
- NextPC  input  1  unconditional PC increment strobe from the main FSM
- RegW  input  1  register-file write request
- MemW  input  1  memory write request
- Stall  input  1  freeze all internal state, suppress writes
- CondEx  output  1  combinational condition result for the current Cond and Flags
- Flags  output  4  registered {N,Z,C,V}
- PCWrite  output  1  gated PC write enable
- RegWrite  output  1  gated register write enable
- MemWrite  output  1  gated memory write enable
- CondFault  output  1  sticky unpredictable-condition flag (see Configuration)

## Operation
- CondEx is `condcheck`(Cond, Flags), with one exception: when Cond = 4'b1111, CondEx = 0. CondEx is never X.
- Flag register:
  - Flags[3:2] load ALUFlags[3:2] at a clock edge when FlagW[1] & CondEx & ~Stall.
  - Flags[1:0] load ALUFlags[1:0] when FlagW[0] & CondEx & ~Stall.
  - Each half is written independently.
- CondExDelayed register: loads CondEx on every edge where ~Stall, and holds while Stall = 1.
- Write gating (combinational):
  - PCWrite = ~Stall & ((PCS & CondExDelayed) | NextPC)
  - RegWrite = ~Stall & RegW & CondExDelayed
  - MemWrite = ~Stall & MemW & CondExDelayed
- NextPC bypasses the condition: a failed-condition instruction still advances the PC.
- Simultaneous flag write and evaluation: CondEx uses the pre-edge Flags. A flag update becomes visible to CondEx one cycle later.

## Timing
- Reset (reset = 0, asynchronous): Flags = 4'b0000, CondExDelayed = 0, CondFault = 0. All gated enables are 0 while in reset. NextPC is gated by reset too.
- Reset released mid-instruction: the first edge after release samples CondEx normally. No pending state survives reset.
- CondEx latency: 0 cycles from Cond/Flags.
- Flags latency: 1 cycle from the FlagW edge.
- Write enables: they reflect the CondEx sampled at the previous non-stalled edge. The controller raises FlagW/RegW/MemW/PCS in the execute or writeback state, which is at least one cycle after decode.
- Stall = 1: CondExDelayed, Flags and CondFault hold, and all three enables are 0. Stall overrides NextPC.

## Configuration
- `CONDLOGIC_NV_TRAP_EN` defined:
  - Cond = 4'b1111 at a non-stalled edge sets CondFault = 1.
  - CondFault stays 1 (sticky) until reset.
  - CondEx is still forced 0.
- Not defined:
  - CondFault is tied to 0 and no register is built.
  - 4'b1111 behaves as "never".

## Structure
- Shared package `arm_cond_pkg`:
  - condition-code constants EQ..AL and NV (4'b0000..4'b1111)
  - flag bit indices N=3, Z=2, C=1, V=0
  - FlagW bit indices FW_NZ=1, FW_CV=0
- One sub-module: instance `u_condcheck` of the existing `condcheck`. The NV mask is applied outside it.
- Flag halves and CondExDelayed are separate async-reset flops with enables.

## Test plan
- Reset: reset = 0 with arbitrary inputs → Flags = 0000, PCWrite = RegWrite = MemWrite = CondFault = 0. Release reset, Cond = 1110, next edge → CondEx = 1.
- Full flag write: Cond = 1110, FlagW = 11, ALUFlags = 0110, one edge → Flags = 0110. Then Cond = 0000 (EQ) → CondEx = 1 in that same cycle.
- Partial write: Flags = 0110, FlagW = 10, ALUFlags = 1001 → Flags = 1010. With FlagW = 01 instead → Flags = 0101.
- Gating:
  - Flags = 0000, Cond = 0000, RegW = MemW = PCS = 1 → after one edge, RegWrite = MemWrite = PCWrite = 0.
  - Same with Flags = 0100 → all three enables = 1.
  - NextPC = 1 with a failed condition → PCWrite = 1.
- Stall: CondExDelayed = 1, Stall = 1, RegW = 1, FlagW = 11 → RegWrite = 0, and Flags are unchanged across 3 edges. Drop Stall → RegWrite = 1.
- NV:
  - Cond = 1111 → CondEx = 0.
  - With `CONDLOGIC_NV_TRAP_EN`: CondFault = 1 after the edge and stays 1 after Cond returns to 1110, until reset = 0.
  - Without the macro: CondFault stays 0.
